// File: rtl/control_sequencer.sv
// Hardwired microsequencer for the Simple-CPU datapath: fetch/decode/execute
// loop that emits one registered 16-bit control word per step, each held HOLD_CYCLES.
module control_sequencer #(
  parameter int HOLD_CYCLES = 2,
  parameter int OP_W        = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [OP_W-1:0] opcode,
  input  logic            acc_sign,
  output logic [15:0]     control_signals,
  output logic            instr_done,
  output logic            halted
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_PEN  = HOLD_W'(HOLD_CYCLES - 2);

  localparam logic [15:0] W_NONE    = 16'h0000;
  localparam logic [15:0] W_F0      = 16'h0001;
  localparam logic [15:0] W_F1      = 16'h0012;
  localparam logic [15:0] W_F2      = 16'h000C;
  localparam logic [15:0] W_READ    = 16'h0002;
  localparam logic [15:0] W_MBR_ACC = 16'h0020;
  localparam logic [15:0] W_WRITE   = 16'h0040;
  localparam logic [15:0] W_BR      = 16'h0080;
  localparam logic [15:0] W_CLR     = 16'h0100;
  localparam logic [15:0] W_JUMP    = 16'h0200;
  localparam logic [15:0] W_ADD     = 16'h0400;
  localparam logic [15:0] W_SUB     = 16'h0800;
  localparam logic [15:0] W_AND     = 16'h1000;
  localparam logic [15:0] W_OR      = 16'h2000;

  localparam logic [OP_W-1:0] OP_STORE  = OP_W'(8'h01);
  localparam logic [OP_W-1:0] OP_LOAD   = OP_W'(8'h02);
  localparam logic [OP_W-1:0] OP_ADD    = OP_W'(8'h03);
  localparam logic [OP_W-1:0] OP_SUB    = OP_W'(8'h04);
  localparam logic [OP_W-1:0] OP_JMPGEZ = OP_W'(8'h05);
  localparam logic [OP_W-1:0] OP_JMP    = OP_W'(8'h06);
  localparam logic [OP_W-1:0] OP_HALT   = OP_W'(8'h07);
  localparam logic [OP_W-1:0] OP_AND    = OP_W'(8'h08);
  localparam logic [OP_W-1:0] OP_OR     = OP_W'(8'h09);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_DEC, S_E0, S_E1, S_E2, S_E3, S_HALT
  } state_t;

  state_t            r_state;
  logic [HOLD_W-1:0] r_hold;
  logic [OP_W-1:0]   r_op;
  logic              r_sign;

  logic       w_in_exec;
  logic       w_last_exec;
  logic [2:0] w_exec_idx;
  logic [2:0] w_next_idx;

  // Number of execute steps; HALT never reaches execute, unknown opcodes run one NOP step.
  function automatic logic [2:0] exec_len(input logic [OP_W-1:0] op);
    case (op)
      OP_STORE:                      return 3'd2;
      OP_LOAD:                       return 3'd4;
      OP_ADD, OP_SUB, OP_AND, OP_OR: return 3'd3;
      default:                       return 3'd1;
    endcase
  endfunction

  function automatic logic [15:0] alu_seq(input logic [1:0] idx, input logic [15:0] w_final);
    case (idx)
      2'd0:    return W_READ;
      2'd1:    return W_BR;
      default: return w_final;
    endcase
  endfunction

  function automatic logic [15:0] exec_word(input logic [OP_W-1:0] op, input logic sign,
                                            input logic [1:0] idx);
    case (op)
      OP_STORE:  return (idx == 2'd0) ? W_MBR_ACC : W_WRITE;
      OP_LOAD:   return (idx == 2'd2) ? W_CLR : alu_seq(idx, W_ADD);
      OP_ADD:    return alu_seq(idx, W_ADD);
      OP_SUB:    return alu_seq(idx, W_SUB);
      OP_AND:    return alu_seq(idx, W_AND);
      OP_OR:     return alu_seq(idx, W_OR);
      OP_JMP:    return W_JUMP;
      OP_JMPGEZ: return sign ? W_NONE : W_JUMP;
      default:   return W_NONE;
    endcase
  endfunction

  function automatic state_t exec_state(input logic [1:0] idx);
    case (idx)
      2'd0:    return S_E0;
      2'd1:    return S_E1;
      2'd2:    return S_E2;
      default: return S_E3;
    endcase
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    w_in_exec  = 1'b0;
    w_exec_idx = 3'd0;
    case (r_state)
      S_E0:    begin w_in_exec = 1'b1; w_exec_idx = 3'd0; end
      S_E1:    begin w_in_exec = 1'b1; w_exec_idx = 3'd1; end
      S_E2:    begin w_in_exec = 1'b1; w_exec_idx = 3'd2; end
      S_E3:    begin w_in_exec = 1'b1; w_exec_idx = 3'd3; end
      default: ;
    endcase
    w_next_idx  = w_exec_idx + 3'd1;
    w_last_exec = w_in_exec && (w_next_idx == exec_len(r_op));
  end

  // NOTE: all state and outputs update with non-blocking assignments so every
  // read in this block sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_hold          <= '0;
      r_op            <= '0;
      r_sign          <= 1'b0;
      control_signals <= W_NONE;
      instr_done      <= 1'b0;
      halted          <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state         <= S_F0;
            r_hold          <= '0;
            control_signals <= W_F0;
          end
        end
        S_HALT: ;
        default: begin
          if (r_hold != HOLD_LAST) begin
            r_hold <= r_hold + 1'b1;
            // Raise done one edge early so it lands on the final hold cycle.
            if (r_hold == HOLD_PEN && w_last_exec) instr_done <= 1'b1;
          end else begin
            r_hold <= '0;
            case (r_state)
              S_F0: begin r_state <= S_F1;  control_signals <= W_F1;   end
              S_F1: begin r_state <= S_F2;  control_signals <= W_F2;   end
              S_F2: begin r_state <= S_DEC; control_signals <= W_NONE; end
              S_DEC: begin
                // The opcode is used here directly because the latch updates on this same edge.
                r_op   <= opcode;
                r_sign <= acc_sign;
                if (opcode == OP_HALT) begin
                  r_state         <= S_HALT;
                  control_signals <= W_NONE;
                  halted          <= 1'b1;
                end else begin
                  r_state         <= S_E0;
                  control_signals <= exec_word(opcode, acc_sign, 2'd0);
                end
              end
              default: begin
                if (w_last_exec) begin
                  r_state         <= S_F0;
                  control_signals <= W_F0;
                end else begin
                  r_state         <= exec_state(w_next_idx[1:0]);
                  control_signals <= exec_word(r_op, r_sign, w_next_idx[1:0]);
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
